// File: rtl/io_uart_tx_if.sv
// Core IO memory-stage bus: byte address, write data/strobe and combinational read data.
interface io_uart_tx_if;
  logic [31:0] IO_mem_addr;
  logic [31:0] IO_mem_wdata;
  logic        IO_mem_wr;
  logic [31:0] IO_mem_rdata;

  modport master (output IO_mem_addr, output IO_mem_wdata, output IO_mem_wr, input IO_mem_rdata);
  modport slave  (input IO_mem_addr, input IO_mem_wdata, input IO_mem_wr, output IO_mem_rdata);
endinterface

// File: rtl/io_uart_tx.sv
// Memory-mapped LED register plus FIFO-buffered 8N1 UART transmitter.
// Word-address bits select targets one-hot: bit0 LED, bit1 UART data/status, bit2 status-clear.
module io_uart_tx #(
  parameter int BAUD_DIV  = 234,
  parameter int FIFO_LOG2 = 3
) (
  input  logic          clk,
  input  logic          resetn,
  io_uart_tx_if.slave   bus,
  output logic          uart_txd,
  output logic [5:0]    leds
);
  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam logic [15:0] BAUD_RELOAD = 16'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state;
  logic [15:0]          baud;
  logic [2:0]           bit_idx;
  logic [7:0]           shift;
  logic [7:0]           mem [DEPTH];
  logic [FIFO_LOG2-1:0] wr_ptr, rd_ptr;
  logic [FIFO_LOG2:0]   count;
  logic                 overflow;

  logic [13:0] word;
  logic        sel_led, sel_uart, sel_clr;
  logic        fifo_empty, fifo_full, pop, push, drop, busy;
  logic [7:0]  head;

  assign word     = bus.IO_mem_addr[15:2];
  assign sel_led  = bus.IO_mem_wr & word[0];
  assign sel_uart = bus.IO_mem_wr & word[1];
  assign sel_clr  = bus.IO_mem_wr & word[2];

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (FIFO_LOG2+1)'(DEPTH));
  assign head       = mem[rd_ptr];
  // A pop frees a slot in the same edge, so a push to a full FIFO still lands then.
  assign pop  = !fifo_empty && (state == IDLE || (state == STOP && baud == '0));
  assign push = sel_uart && (!fifo_full || pop);
  assign drop = sel_uart && fifo_full && !pop;
  assign busy = !fifo_empty || (state != IDLE);

  always_comb begin
    bus.IO_mem_rdata = '0;
    if (word[1])
      bus.IO_mem_rdata = {21'b0, overflow, busy, fifo_full, 4'b0, 4'(count)};
    else if (word[0])
      bus.IO_mem_rdata = {26'b0, leds};
  end

  always_ff @(posedge clk) begin
    if (resetn && push) mem[wr_ptr] <= bus.IO_mem_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      leds     <= '0;
    end else begin
      if (sel_led) leds <= bus.IO_mem_wdata[5:0];
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      // A dropped byte wins over a simultaneous clear.
      if (drop)         overflow <= 1'b1;
      else if (sel_clr) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      uart_txd <= 1'b1;
      baud     <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      case (state)
        IDLE: begin
          uart_txd <= 1'b1;
          if (!fifo_empty) begin
            shift    <= head;
            baud     <= BAUD_RELOAD;
            state    <= START;
            uart_txd <= 1'b0;
          end
        end
        START: begin
          if (baud == '0) begin
            baud     <= BAUD_RELOAD;
            bit_idx  <= '0;
            state    <= DATA;
            uart_txd <= shift[0];
          end else begin
            baud <= baud - 16'd1;
          end
        end
        DATA: begin
          if (baud == '0) begin
            baud  <= BAUD_RELOAD;
            shift <= shift >> 1;
            if (bit_idx == 3'd7) begin
              state    <= STOP;
              uart_txd <= 1'b1;
            end else begin
              bit_idx  <= bit_idx + 3'd1;
              uart_txd <= shift[1];
            end
          end else begin
            baud <= baud - 16'd1;
          end
        end
        STOP: begin
          if (baud == '0) begin
            // Chain straight into the next start bit when more data is queued.
            if (!fifo_empty) begin
              shift    <= head;
              baud     <= BAUD_RELOAD;
              state    <= START;
              uart_txd <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud <= baud - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bus.IO_mem_addr[31:16], bus.IO_mem_addr[1:0], word[13:3], bus.IO_mem_wdata[31:8]};
endmodule
